// File: rtl/add1_serial_driver.sv
`default_nettype none
// ============================================================================
// Module   : add1_serial_driver
// Brief    : Parallel handshake front-end for the bit-serial Add1 incrementer.
//            Optional result self-check is enabled by defining ADD1_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module add1_serial_driver #(
  parameter int NUMBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] in_data,
  output logic               ser_reset,
  output logic               ser_out,
  input  logic               ser_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] out_data,
  output logic               chk_err
);

  localparam int IDX_W = (NUMBITS > 1) ? $clog2(NUMBITS) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUMBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUMBITS-1:0] shift_q, shift_d;
  logic [NUMBITS-1:0] collect_q, collect_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    collect_d = collect_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    ser_reset = 1'b0;
    ser_out   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_d   = in_data;
          collect_d = '0;
          idx_d     = '0;
          state_d   = S_FRAME;
        end
      end
      S_FRAME: begin
        ser_reset = 1'b1;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        // ser_in is the incrementer's Mealy response to the bit driven now
        ser_out            = shift_q[0];
        collect_d[idx_q]   = ser_in;
        shift_d            = shift_q >> 1;
        idx_d              = idx_q + IDX_W'(1);
        if (idx_q == c_LAST_IDX) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      collect_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      collect_q <= collect_d;
      idx_q     <= idx_d;
    end
  end

  assign out_data = collect_q;

`ifdef ADD1_CHECK_EN
  logic [NUMBITS-1:0] word_q, word_d;
  logic [NUMBITS-1:0] w_expect;
  logic               chk_q, chk_d;

  assign w_expect = word_q + NUMBITS'(1);

  always_comb begin
    word_d = word_q;
    chk_d  = chk_q;
    if (state_q == S_IDLE && in_valid) begin
      word_d = in_data;
    end
    // Flag is decided once on entry to DONE and held until DONE is left
    if (state_q == S_SHIFT && state_d == S_DONE) begin
      chk_d = (collect_d != w_expect);
    end else if (state_q == S_DONE && state_d != S_DONE) begin
      chk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      chk_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      chk_q  <= chk_d;
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add1_serial_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_add1_serial_driver
// Brief    : Directed self-checking bench with a behavioural serial Add1 model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add1_serial_driver;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_data;
  logic          ser_reset;
  logic          ser_out;
  logic          ser_in;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_data;
  logic          chk_err;

  int n_cmp = 0;
  int n_err = 0;

  logic carry_q = 1'b0;
  logic stub_zero = 1'b0;

`ifdef ADD1_CHECK_EN
  localparam logic c_CHK_ON = 1'b1;
`else
  localparam logic c_CHK_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference bit-serial incrementer: carry preset by frame reset
  always @(posedge clk) begin
    if (ser_reset) carry_q <= 1'b1;
    else           carry_q <= carry_q & ser_out;
  end
  assign ser_in = stub_zero ? 1'b0 : (ser_out ^ carry_q);

  add1_serial_driver #(.NUMBITS(NB)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ser_reset (ser_reset),
    .ser_out   (ser_out),
    .ser_in    (ser_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .chk_err   (chk_err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    n_cmp++;
    if ({in_ready, ser_reset, ser_out, out_valid, out_data, chk_err} !== {4'b1000, 4'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b srst=%b sout=%b ov=%b od=%h ce=%b, want rdy=1 srst=0 sout=0 ov=0 od=0 ce=0",
               in_ready, ser_reset, ser_out, out_valid, out_data, chk_err);
    end
  endtask

  task automatic test_basic();
    logic [3:0] bits;
    bits = 4'b0101;
    in_data = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({ser_reset, ser_out, in_ready} !== 3'b100) begin
      n_err++;
      $display("FAIL basic_frame: got srst=%b sout=%b rdy=%b, want 1 0 0", ser_reset, ser_out, in_ready);
    end
    for (int i = 0; i < NB; i++) begin
      tick();
      n_cmp++;
      if ({ser_reset, ser_out, out_valid} !== {1'b0, bits[i], 1'b0}) begin
        n_err++;
        $display("FAIL basic_shift%0d: got srst=%b sout=%b ov=%b, want 0 %b 0", i, ser_reset, ser_out, out_valid, bits[i]);
      end
    end
    tick();
    n_cmp++;
    if ({out_valid, out_data, chk_err} !== {1'b1, 4'd6, 1'b0}) begin
      n_err++;
      $display("FAIL basic_result: got ov=%b od=%h ce=%b, want 1 6 0", out_valid, out_data, chk_err);
    end
    tick();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL basic_return: got ov=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_wrap();
    in_data = 4'hF; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (NB + 1) tick();
    n_cmp++;
    if ({out_valid, out_data, chk_err} !== {1'b1, 4'h0, 1'b0}) begin
      n_err++;
      $display("FAIL wrap_result: got ov=%b od=%h ce=%b, want 1 0 0", out_valid, out_data, chk_err);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    logic       busy_ok;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int v = 0; v < 16; v++) begin
      in_data = 4'(v);
      exp     = 4'(v + 1);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready%0d: got rdy=%b, want 1", v, in_ready);
      end
      busy_ok = 1'b1;
      for (int c = 1; c <= NB + 2; c++) begin
        tick();
        if (in_ready !== 1'b0) busy_ok = 1'b0;
      end
      n_cmp++;
      if ({busy_ok, out_valid, out_data} !== {1'b1, 1'b1, exp}) begin
        n_err++;
        $display("FAIL b2b_word%0d: got busy_ok=%b ov=%b od=%h, want 1 1 %h", v, busy_ok, out_valid, out_data, exp);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    in_data = 4'd3; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (NB + 1) tick();
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if ({out_valid, out_data, in_ready} !== {1'b1, 4'd4, 1'b0}) begin
        n_err++;
        $display("FAIL hold%0d: got ov=%b od=%h rdy=%b, want 1 4 0", c, out_valid, out_data, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL hold_release: got ov=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_valid;
    in_data = 4'd7; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    // third SHIFT cycle: assert reset together with a competing word
    reset = 1'b1; in_valid = 1'b1; in_data = 4'd12;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if ({in_ready, ser_reset, ser_out, out_valid, out_data, chk_err} !== {4'b1000, 4'h0, 1'b0}) begin
      n_err++;
      $display("FAIL midreset_state: got rdy=%b srst=%b sout=%b ov=%b od=%h ce=%b, want 1 0 0 0 0 0",
               in_ready, ser_reset, ser_out, out_valid, out_data, chk_err);
    end
    saw_valid = 1'b0;
    for (int c = 0; c < NB + 4; c++) begin
      tick();
      if (out_valid !== 1'b0 || ser_reset !== 1'b0) saw_valid = 1'b1;
    end
    n_cmp++;
    if (saw_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_discard: got activity=%b, want 0", saw_valid);
    end
    in_data = 4'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (NB + 1) tick();
    n_cmp++;
    if ({out_valid, out_data} !== {1'b1, 4'd10}) begin
      n_err++;
      $display("FAIL midreset_next: got ov=%b od=%h, want 1 a", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_check_stub();
    stub_zero = 1'b1;
    in_data = 4'd2; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (NB + 1) tick();
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if ({out_valid, out_data, chk_err} !== {1'b1, 4'd0, c_CHK_ON}) begin
        n_err++;
        $display("FAIL chk_done%0d: got ov=%b od=%h ce=%b, want 1 0 %b", c, out_valid, out_data, chk_err, c_CHK_ON);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, chk_err} !== 2'b00) begin
      n_err++;
      $display("FAIL chk_clear: got ov=%b ce=%b, want 0 0", out_valid, chk_err);
    end
    stub_zero = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_check_stub();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
